// File: rtl/encoder_16_4_pkg.sv
// rtl/encoder_16_4_pkg.sv - shared widths and types for the 16-to-4 priority encoder
package enc16_pkg;

    localparam int ENC_IN_W  = 16;
    localparam int ENC_OUT_W = 4;

    typedef logic [ENC_IN_W-1:0]  enc_req_t;
    typedef logic [ENC_OUT_W-1:0] enc_idx_t;

endpackage

// File: rtl/encoder_16_4_if.sv
// rtl/encoder_16_4_if.sv - request/result bundle for encoder_16_4 (multi_hot present under ENC16_MULTI_HOT_EN)
interface encoder_16_4_if;
    import enc16_pkg::*;

    enc_req_t i;
    logic     enable;
    enc_idx_t o;
    logic     valid;
`ifdef ENC16_MULTI_HOT_EN
    logic     multi_hot;

    modport master (output i, output enable, input o, input valid, input multi_hot);
    modport slave  (input i, input enable, output o, output valid, output multi_hot);
`else
    modport master (output i, output enable, input o, input valid);
    modport slave  (input i, input enable, output o, output valid);
`endif

endinterface

// File: rtl/encoder_16_4_enc8.sv
// rtl/encoder_16_4_enc8.sv - combinational 8-to-3 priority encoder with any-set flag
module encoder_8_3 (
    input  logic [7:0] d,
    output logic [2:0] idx,
    output logic       any_set
);

    // Ascending scan: the last (highest) set bit seen is the one that sticks.
    always_comb begin
        idx = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (d[k]) begin
                idx = 3'(k);
            end
        end
    end

    assign any_set = |d;

endmodule

// File: rtl/encoder_16_4.sv
// rtl/encoder_16_4.sv - registered 16-to-4 priority encoder, highest set bit wins (optional ENC16_MULTI_HOT_EN)
module encoder_16_4
    import enc16_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    encoder_16_4_if.slave  bus
);

    enc_req_t   req;
    logic [2:0] hi_idx;
    logic [2:0] lo_idx;
    logic       hi_any;
    logic       lo_any;
    enc_idx_t   o_q;
    logic       valid_q;

    assign req = bus.i;

    encoder_8_3 u_hi (
        .d       (req[15:8]),
        .idx     (hi_idx),
        .any_set (hi_any)
    );

    encoder_8_3 u_lo (
        .d       (req[7:0]),
        .idx     (lo_idx),
        .any_set (lo_any)
    );

    // Disabled cycles clear the outputs rather than holding the last result.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_q     <= '0;
            valid_q <= 1'b0;
        end else if (bus.enable) begin
            o_q     <= hi_any ? {1'b1, hi_idx} : {1'b0, lo_idx};
            valid_q <= hi_any | lo_any;
        end else begin
            o_q     <= '0;
            valid_q <= 1'b0;
        end
    end

    assign bus.o     = o_q;
    assign bus.valid = valid_q;

`ifdef ENC16_MULTI_HOT_EN
    logic multi_hot_q;

    // Clearing the lowest set bit leaves something only when two or more were set.
    always_ff @(posedge clk) begin
        if (rst) begin
            multi_hot_q <= 1'b0;
        end else if (bus.enable) begin
            multi_hot_q <= (req & (req - enc_req_t'(1))) != '0;
        end else begin
            multi_hot_q <= 1'b0;
        end
    end

    assign bus.multi_hot = multi_hot_q;
`endif

endmodule

// File: tb/tb_encoder_16_4.sv
// tb/tb_encoder_16_4.sv - randomized self-checking bench for encoder_16_4 (ENC16_MULTI_HOT_EN aware)
module tb_encoder_16_4;
    import enc16_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    encoder_16_4_if bus ();

    encoder_16_4 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_top_bit(input logic [15:0] v);
        for (int b = 15; b >= 0; b--) begin
            if (v[b]) return b;
        end
        return -1;
    endfunction

    // Apply one cycle of stimulus and compare the registered result after the edge.
    task automatic step(input string tag, input logic r, input logic en, input logic [15:0] v);
        int top;
        int exp_o;
        int exp_valid;
        int exp_mh;
        rst        = r;
        bus.enable = en;
        bus.i      = v;
        @(posedge clk);
        #1;
        top       = ref_top_bit(v);
        exp_o     = (!r && en && top >= 0) ? top : 0;
        exp_valid = (!r && en && top >= 0) ? 1 : 0;
        exp_mh    = (!r && en && $countones(v) > 1) ? 1 : 0;
        check({tag, ".o"}, 32'(bus.o), 32'(exp_o));
        check({tag, ".valid"}, 32'(bus.valid), 32'(exp_valid));
        check({tag, ".xfree"}, 32'($isunknown({bus.o, bus.valid})), 32'd0);
`ifdef ENC16_MULTI_HOT_EN
        check({tag, ".multi_hot"}, 32'(bus.multi_hot), 32'(exp_mh));
`endif
    endtask

    logic [15:0] tbl_a [8] = '{16'h0011, 16'h0012, 16'h0014, 16'h0018,
                               16'h0110, 16'h0120, 16'h0140, 16'h0280};
    logic [15:0] tbl_b [8] = '{16'h2100, 16'h3200, 16'h2400, 16'h2800,
                               16'h1000, 16'h2000, 16'h4000, 16'h8000};
    int          exp_a [8] = '{4, 4, 4, 4, 8, 8, 8, 9};
    int          exp_b [8] = '{13, 13, 13, 13, 12, 13, 14, 15};

    initial begin
        rst        = 1'b1;
        bus.enable = 1'b1;
        bus.i      = 16'hFFFF;

        step("reset0", 1'b1, 1'b1, 16'hFFFF);
        step("reset1", 1'b1, 1'b1, 16'hFFFF);
        step("release", 1'b0, 1'b1, 16'hFFFF);
        check("release.o_is_15", 32'(bus.o), 32'd15);

        for (int k = 0; k < 8; k++) begin
            step("tbl_a", 1'b0, 1'b1, tbl_a[k]);
            check("tbl_a.const", 32'(bus.o), 32'(exp_a[k]));
        end
        for (int k = 0; k < 8; k++) begin
            step("tbl_b", 1'b0, 1'b1, tbl_b[k]);
            check("tbl_b.const", 32'(bus.o), 32'(exp_b[k]));
        end

        step("bit0", 1'b0, 1'b1, 16'h0001);
        check("bit0.valid_set", 32'(bus.valid), 32'd1);
        step("zero", 1'b0, 1'b1, 16'h0000);
        check("zero.valid_clr", 32'(bus.valid), 32'd0);

        for (int k = 0; k < 16; k++) begin
            step("walk", 1'b0, 1'b1, 16'(1) << k);
            check("walk.idx", 32'(bus.o), 32'(k));
        end
        step("en_off", 1'b0, 1'b0, 16'h8421);
        step("en_off2", 1'b0, 1'b0, 16'hFFFF);
        step("en_on", 1'b0, 1'b1, 16'h0400);
        check("en_on.idx", 32'(bus.o), 32'd10);

`ifdef ENC16_MULTI_HOT_EN
        step("mh_0280", 1'b0, 1'b1, 16'h0280);
        check("mh_0280.const", 32'(bus.multi_hot), 32'd1);
        step("mh_8000", 1'b0, 1'b1, 16'h8000);
        check("mh_8000.const", 32'(bus.multi_hot), 32'd0);
        step("mh_pre", 1'b0, 1'b1, 16'hF00F);
        step("mh_rst", 1'b1, 1'b1, 16'hF00F);
        check("mh_rst.const", 32'(bus.multi_hot), 32'd0);
`endif

        for (int n = 0; n < 400; n++) begin
            logic [15:0] v;
            logic        en;
            logic        r;
            case ($urandom_range(3))
                0: v = 16'($urandom);
                1: v = 16'(1) << $urandom_range(15);
                2: v = (16'(1) << $urandom_range(15)) | (16'(1) << $urandom_range(15));
                default: v = 16'($urandom) >> $urandom_range(15);
            endcase
            en = ($urandom_range(7) != 0);
            r  = ($urandom_range(31) == 0);
            step("rand", r, en, v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/encoder_16_4.md
Name: encoder_16_4

Overview:
- Registered 16-to-4 priority encoder. Reports the index of the highest-numbered asserted bit of a 16-bit request vector.
- Used as a generic arbitration/index-extraction leaf wherever a one-of-16 (or multi-hot) request vector must be reduced to a binary index.
- Result is presented one clock after sampling, with a valid flag.

Parameters:
- None. Widths are fixed at 16 in / 4 out via package constants.

Ports:
- clk  input  1  sole clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- o  output  4  registered index of the highest set bit of i
- i  input  16  request vector; bit 15 has highest priority
- enable  input  1  encode enable; sampled on rising clk edge
- valid  output  1  registered; 1 when o holds an encode of a non-zero i

Behaviour:
- Interface (fixed): one clock (clk); reset rst is synchronous and active-high.
- Reset: when rst=1 at a rising edge, o<=4'd0 and valid<=0. Reset overrides enable and i.
- Priority: the highest set bit index wins. Lower bits are don't-care once a higher bit is set.
  - Example: i=16'h3200 has bits 13, 12 and 9 set, so o=13.
- Latency: exactly 1 cycle. At edge N, with rst=0 and enable=1, i is sampled; o/valid reflect it after edge N.
- Zero input: enable=1 and i=16'h0000 gives o<=0, valid<=0.
  - o=0 with valid=1 only for i whose highest set bit is bit 0.
- enable=0 (rst=0): o<=0 and valid<=0 at the next edge. Outputs do not hold their previous value.
- Throughput: a new i is accepted every cycle. There is no handshake and no backpressure.
- Outputs are purely registered. There is no combinational path from i/enable to o/valid.
- X-free: every output bit has a defined value in every cycle after the first reset.

Optional Feature:
- Macro: ENC16_MULTI_HOT_EN.
- Defined:
  - Adds output port multi_hot (1 bit, registered, same latency as o).
  - multi_hot=1 when enable=1 and more than one bit of i is set; 0 otherwise.
  - Cleared by rst and by enable=0.
- Undefined: the port and its logic are absent. o/valid behaviour is identical in both builds.

Decomposition:
- Package enc16_pkg holds:
  - ENC_IN_W=16 and ENC_OUT_W=4.
  - typedef enc_req_t (logic [15:0]) and enc_idx_t (logic [3:0]).
- Sub-module encoder_8_3 (combinational 8-to-3 priority encoder plus any-set flag):
  - Two instances cover the upper and lower bytes.
  - Top level: if the upper byte is non-zero, o={1, upper idx}; else o={0, lower idx}.
  - valid = upper_any | lower_any.

Test Plan:
- rst=1 for 2 cycles with i=16'hFFFF, enable=1 -> o=0, valid=0. Release rst -> o=15, valid=1 one cycle later.
- enable=1, sequence i=16'h0011, 0012, 0014, 0018, 0110, 0120, 0140, 0280 one per cycle -> o = 4, 4, 4, 4, 8, 8, 8, 9 (each lagging by one cycle), valid=1 throughout.
- i=16'h2100, 3200, 2400, 2800, 1000, 2000, 4000, 8000 -> o = 13, 13, 13, 13, 12, 13, 14, 15.
- i=16'h0001 -> o=0, valid=1. Then i=16'h0000 -> o=0, valid=0.
- Walking one over bits 0..15 back-to-back -> o=k one cycle after bit k is applied. Then drop enable=0 mid-stream -> o=0, valid=0 next cycle, resuming one cycle after enable returns.
- With ENC16_MULTI_HOT_EN defined:
  - i=16'h0280 -> multi_hot=1.
  - i=16'h8000 -> multi_hot=0.
  - rst mid-stream -> multi_hot=0.
